ascii_seg_pacer: RTL and testbench

- Downstream consumer of the character-stream generator that walks the stored text (volcano names, space-separated).
- Accepts one ASCII byte per valid/ready handshake and drives a single 7-segment digit.
- Holds each character for a programmable dwell time, then blanks the digit for a gap. Repeated letters (e.g. "aa") therefore stay visually distinct.
- Spaces show as a blank digit with the decimal point lit, marking word boundaries.

---
 rtl/ascii_seg_pkg.sv | 55 +++++
 rtl/ascii_seg_pacer_if.sv | 16 +
 rtl/ascii_seg_lut.sv | 16 +
 rtl/ascii_seg_pacer.sv | 103 ++++++++++
 tb/tb_ascii_seg_pacer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_seg_pkg.sv
// ascii_seg_pkg: shared types and constants for the ASCII 7-segment pacer.
//   pacer_state_t : IDLE / SHOW / GAP phase of the pacer
//   SEG_BLANK     : all segments off
//   SEG_DASH      : segment g only, shown for codes without a glyph
//   ASCII_SPACE   : word separator, shown as blank digit plus decimal point
//   glyph_of()    : ASCII byte -> {g,f,e,d,c,b,a} pattern, case-insensitive
package ascii_seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } pacer_state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h00;
  localparam logic [6:0] SEG_DASH    = 7'h40;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Lower-case letters are folded onto upper case first so both share a glyph.
  function automatic logic [6:0] glyph_of(input logic [7:0] c);
    logic [7:0] u;
    logic [6:0] g;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      8'h20:   g = SEG_BLANK;
      8'h30:   g = 7'h3F;  // 0
      8'h31:   g = 7'h06;  // 1
      8'h32:   g = 7'h5B;  // 2
      8'h33:   g = 7'h4F;  // 3
      8'h34:   g = 7'h66;  // 4
      8'h35:   g = 7'h6D;  // 5
      8'h36:   g = 7'h7D;  // 6
      8'h37:   g = 7'h07;  // 7
      8'h38:   g = 7'h7F;  // 8
      8'h39:   g = 7'h6F;  // 9
      8'h41:   g = 7'h77;  // A
      8'h43:   g = 7'h39;  // C
      8'h45:   g = 7'h79;  // E
      8'h46:   g = 7'h71;  // F
      8'h47:   g = 7'h3D;  // G
      8'h4A:   g = 7'h1E;  // J
      8'h4C:   g = 7'h38;  // L
      8'h4D:   g = 7'h37;  // M
      8'h4E:   g = 7'h37;  // N
      8'h4F:   g = 7'h3F;  // O
      8'h52:   g = 7'h50;  // R
      8'h53:   g = 7'h6D;  // S
      8'h54:   g = 7'h78;  // T
      8'h55:   g = 7'h3E;  // U
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ascii_seg_pacer_if.sv
// ascii_seg_pacer_if: character handshake between the text generator and the pacer.
//   char_in    : ASCII byte, driven by master
//   char_valid : char_in holds a character, driven by master
//   char_ready : slave can take a character this cycle, driven by slave
// Handshake: a byte transfers on the rising clock edge where char_valid and
// char_ready are both high. While char_valid is high and no transfer has
// happened, the master keeps char_in stable. char_ready never depends on
// char_valid, so no combinational loop can form between the two sides.
interface ascii_seg_pacer_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_in, output char_valid, input  char_ready);
  modport slave  (input  char_in, input  char_valid, output char_ready);
endinterface

// File: rtl/ascii_seg_lut.sv
// ascii_seg_lut: combinational ASCII -> 7-segment decoder.
//   i_char     : ASCII byte
//   o_seg      : {g,f,e,d,c,b,a}, active high
//   o_is_space : i_char is the space separator
module ascii_seg_lut
  import ascii_seg_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [6:0] o_seg,
  output logic       o_is_space
);

  assign o_seg      = glyph_of(i_char);
  assign o_is_space = (i_char == ASCII_SPACE);

endmodule

// File: rtl/ascii_seg_pacer.sv
// ascii_seg_pacer: shows one ASCII character at a time on a single 7-segment
// digit, holding it HOLD_CYCLES cycles and then blanking for GAP_CYCLES cycles
// so repeated letters stay distinct.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable; low freezes state, counter and outputs
//   char_if    : slave side of the character handshake (char_in/valid/ready)
//   seg, dp    : registered segment and decimal-point drive, active high
//   busy       : high in SHOW or GAP
//   char_done  : one-cycle pulse after a character's GAP finishes
//   dbg_state  : current pacer state
module ascii_seg_pacer
  import ascii_seg_pkg::*;
#(
  parameter int HOLD_CYCLES = 12_000_000,
  parameter int GAP_CYCLES  = 1_200_000,
  parameter int CNT_W       = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  ascii_seg_pacer_if.slave    char_if,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                busy,
  output logic                char_done,
  output pacer_state_t        dbg_state
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  pacer_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_char_done;

  logic [6:0]       w_glyph;
  logic             w_is_space;
  logic             w_ready;

  ascii_seg_lut u_lut (
    .i_char     (char_if.char_in),
    .o_seg      (w_glyph),
    .o_is_space (w_is_space)
  );

  // rst_n is included so the upstream sees no ready while reset is held.
  assign w_ready            = (r_state == IDLE) && ena && rst_n;
  assign char_if.char_ready = w_ready;

  // Counter is loaded with N-1 and the phase ends on the cycle it reads zero,
  // so each phase lasts exactly N enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b0;
      r_char_done <= 1'b0;
    end else begin
      r_char_done <= 1'b0;
      if (ena) begin
        case (r_state)
          IDLE: begin
            if (char_if.char_valid && w_ready) begin
              r_seg   <= w_glyph;
              r_dp    <= w_is_space;
              r_cnt   <= HOLD_LOAD;
              r_state <= SHOW;
            end
          end
          SHOW: begin
            if (r_cnt == '0) begin
              r_seg   <= SEG_BLANK;
              r_dp    <= 1'b0;
              r_cnt   <= GAP_LOAD;
              r_state <= GAP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          GAP: begin
            if (r_cnt == '0) begin
              r_char_done <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign busy      = (r_state != IDLE);
  assign char_done = r_char_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ascii_seg_pacer.sv
module tb_ascii_seg_pacer;
  import ascii_seg_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int CW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic [6:0] seg;
  logic dp, busy, char_done;
  pacer_state_t dbg_state;

  always #5 clk = ~clk;

  ascii_seg_pacer_if u_if ();

  ascii_seg_pacer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .char_if   (u_if),
    .seg       (seg),
    .dp        (dp),
    .busy      (busy),
    .char_done (char_done),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Glyph table as written for the display: upper/lower case fold together.
  function automatic logic [6:0] ref_glyph(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h20: return 7'h00;
      "0": return 7'h3F; "1": return 7'h06; "2": return 7'h5B; "3": return 7'h4F;
      "4": return 7'h66; "5": return 7'h6D; "6": return 7'h7D; "7": return 7'h07;
      "8": return 7'h7F; "9": return 7'h6F;
      "A": return 7'h77; "C": return 7'h39; "E": return 7'h79; "F": return 7'h71;
      "G": return 7'h3D; "J": return 7'h1E; "L": return 7'h38; "M": return 7'h37;
      "N": return 7'h37; "O": return 7'h3F; "R": return 7'h50; "S": return 7'h6D;
      "T": return 7'h78; "U": return 7'h3E;
      default: return 7'h40;
    endcase
  endfunction

  // Model: a character is "active" for HOLD+GAP enabled cycles after its
  // transfer; the first HOLD of those show the glyph.
  bit         m_act = 0;
  bit         m_new = 0;
  int         m_k = 0;
  logic [6:0] m_glyph = '0;
  logic       m_dp = 0;
  logic       m_done = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         xfer_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_new = 0; m_k = 0; m_done = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_done = 0;
      m_new  = 0;
      if (!m_act) begin
        if (ena && u_if.char_valid) begin
          m_act   = 1;
          m_new   = 1;
          m_k     = 0;
          m_glyph = ref_glyph(u_if.char_in);
          m_dp    = (u_if.char_in == 8'h20);
          exp_q.push_back({m_dp, m_glyph});
          xfer_cyc.push_back(cyc);
        end
      end else if (ena) begin
        m_k++;
        if (m_k == HOLD + GAP) begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic [6:0] e_seg;
      logic       e_dp;
      e_seg = (m_act && m_k < HOLD) ? m_glyph : 7'h00;
      e_dp  = (m_act && m_k < HOLD) ? m_dp : 1'b0;
      check("seg", seg, e_seg);
      check("dp", dp, e_dp);
      check("busy", busy, m_act);
      check("char_done", char_done, m_done);
      check("char_ready", u_if.char_ready, (!m_act && ena && rst_n));
      if (m_new && rst_n) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard: glyph shown with empty queue at %0t", $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if ({dp, seg} !== e) begin
            n_err++;
            $display("FAIL first_glyph: got %0h expected %0h at %0t", {dp, seg}, e, $time);
          end
        end
      end
      if (char_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present c and wait for the transfer; returns at posedge+2 of the transfer edge.
  task automatic send(input logic [7:0] c, input bit hold_valid);
    bit ok;
    ok = 0;
    u_if.char_in    = c;
    u_if.char_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (u_if.char_ready) ok = 1;
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: char %0h never accepted", c);
    end
    if (!hold_valid) u_if.char_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick_char();
    logic [7:0] pool [0:15];
    pool = '{8'h54, 8'h61, 8'h41, 8'h20, 8'h30, 8'h39, 8'h46, 8'h55,
             8'h6D, 8'h6E, 8'h62, 8'h7A, 8'h00, 8'h7E, 8'hFF, 8'h72};
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return pool[$urandom_range(0, 15)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, base, d0;
    logic [7:0] edge_c [0:4];
    logic [6:0] edge_g [0:4];
    bit took;

    rst_n = 1'b0; ena = 1'b1;
    u_if.char_in = 8'h00; u_if.char_valid = 1'b0;
    @(posedge clk); #1; chk_on = 1;

    // 1. reset then idle
    @(negedge clk);
    check("ready_in_reset", u_if.char_ready, 1'b0);
    check("seg_in_reset", seg, 7'h00);
    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", u_if.char_ready, 1'b1);
    check("busy_after_reset", busy, 1'b0);
    step();

    // 2. single character 'T'
    d0 = done_cnt;
    send(8'h54, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check("T_first_cycle", seg, 7'h78);
      if (seg == 7'h78) n++;
    end
    check("T_show_cycles", n, HOLD);
    check("T_done_pulses", done_cnt - d0, 1);
    step();

    // 3. stream "Ta a" with valid held high
    base = xfer_cyc.size();
    d0 = done_cnt;
    send(8'h54, 1);
    send(8'h61, 1);
    send(8'h20, 1);
    @(negedge clk);
    check("space_dp", dp, 1'b1);
    check("space_seg", seg, 7'h00);
    send(8'h61, 0);
    repeat (10) step();
    for (int j = 1; j < 4; j++)
      check("xfer_spacing", xfer_cyc[base+j] - xfer_cyc[base+j-1], HOLD + GAP + 1);
    check("stream_done_pulses", done_cnt - d0, 4);

    // 4. unknown / edge codes and case folding
    edge_c = '{8'h00, 8'h7E, 8'hFF, 8'h61, 8'h41};
    edge_g = '{7'h40, 7'h40, 7'h40, 7'h77, 7'h77};
    for (int j = 0; j < 5; j++) begin
      send(edge_c[j], 0);
      @(negedge clk);
      check("edge_seg", seg, edge_g[j]);
      check("edge_dp", dp, 1'b0);
      step();
    end
    repeat (8) step();

    // 5. ena freeze during SHOW of 'F'
    send(8'h46, 0);
    n = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          if (seg == 7'h71) n++;
        end
      end
      begin
        step();
        ena = 1'b0;
        @(negedge clk);
        check("freeze_ready", u_if.char_ready, 1'b0);
        check("freeze_seg", seg, 7'h71);
        step();
        repeat (4) step();
        ena = 1'b1;
      end
    join
    check("F_display_cycles", n, HOLD + 5);
    step();
    repeat (4) step();

    // 6a. reset mid-SHOW of 'U'
    send(8'h55, 0);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_show_seg", seg, 7'h00);
    check("rst_show_busy", busy, 1'b0);
    step(); step();
    rst_n = 1'b1;
    // 6b. reset during GAP of 'U'
    d0 = done_cnt;
    send(8'h55, 0);
    @(negedge clk);
    check("U_seg", seg, 7'h3E);
    step();
    repeat (3) step();
    @(negedge clk);
    check("U_gap_busy", busy, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check("rst_gap_done", char_done, 1'b0);
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_gap_no_pulse", done_cnt - d0, 0);
    send(8'h55, 0);
    @(negedge clk);
    check("U_after_reset", seg, 7'h3E);
    step();
    repeat (8) step();

    // 7. randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      took = u_if.char_ready && u_if.char_valid;
      step();
      if (!u_if.char_valid || took) begin
        u_if.char_in    = pick_char();
        u_if.char_valid = ($urandom_range(0, 2) != 0);
      end
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    u_if.char_valid = 1'b0;
    ena = 1'b1;
    repeat (12) step();

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
